// File: rtl/l15_resp_stub.sv
// L1.5 response stub: one outstanding request, fixed-latency return, small 64-bit backing store.
// Optional: define L15_RESP_STUB_ERR_RET_EN to answer unsupported request types with ERR_RET.
module l15_resp_stub #(
    parameter int TidWidth    = 2,
    parameter int MemWords    = 256,
    parameter int RespLatency = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_val_i,
    input  logic [4:0]          req_rqtype_i,
    input  logic                req_nc_i,
    input  logic [2:0]          req_size_i,
    input  logic [TidWidth-1:0] req_threadid_i,
    input  logic [39:0]         req_address_i,
    input  logic [63:0]         req_data_i,
    input  logic [3:0]          req_amo_op_i,
    input  logic                req_ack_i,
    output logic                rtrn_ack_o,
    output logic                rtrn_header_ack_o,
    output logic                rtrn_val_o,
    output logic [3:0]          rtrn_returntype_o,
    output logic [TidWidth-1:0] rtrn_threadid_o,
    output logic                rtrn_noncacheable_o,
    output logic                rtrn_atomic_o,
    output logic [63:0]         rtrn_data_0_o,
    output logic [63:0]         rtrn_data_1_o,
    output logic [63:0]         rtrn_data_2_o,
    output logic [63:0]         rtrn_data_3_o
);
    localparam int AW = $clog2(MemWords);
    localparam int CW = (RespLatency > 1) ? $clog2(RespLatency) : 1;

    localparam logic [4:0] RQ_LOAD   = 5'b00000;
    localparam logic [4:0] RQ_IMISS  = 5'b10000;
    localparam logic [4:0] RQ_STORE  = 5'b00001;
    localparam logic [4:0] RQ_ATOMIC = 5'b00110;

    localparam logic [3:0] RT_LOAD  = 4'b0000;
    localparam logic [3:0] RT_IFILL = 4'b0001;
    localparam logic [3:0] RT_STACK = 4'b0100;
    localparam logic [3:0] RT_AMO   = 4'b1110;
    localparam logic [3:0] RT_ERR   = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [63:0]         r_mem [MemWords];
    logic [3:0]          r_rtype;
    logic [TidWidth-1:0] r_tid;
    logic                r_nc;
    logic                r_atomic;
    logic [63:0]         r_d0, r_d1, r_d2, r_d3;

    logic                w_accept;
    logic                w_supported;
    logic [AW-1:0]       w_idx, w_idx_l2, w_idx_l4;
    logic [63:0]         w_old;
    logic [7:0]          w_bytemask;
    logic [63:0]         w_bitmask;
    logic [3:0]          w_rtype;
    logic                w_atomic;
    logic [63:0]         w_d0, w_d1, w_d2, w_d3;
    logic                w_wr_en;
    logic [63:0]         w_wr_data;
    logic                w_resp;
    logic                w_unused;

    // Upper address bits are ignored so the store aliases across the address space.
    assign w_idx    = req_address_i[3 +: AW];
    assign w_idx_l2 = {w_idx[AW-1:1], 1'b0};
    assign w_idx_l4 = {w_idx[AW-1:2], 2'b00};
    assign w_old    = r_mem[w_idx];
    assign w_unused = ^req_address_i[39:3+AW];

    always_comb begin
        w_bytemask = 8'h00;
        case (req_size_i)
            3'b000:  w_bytemask = 8'h01 << req_address_i[2:0];
            3'b001:  w_bytemask = 8'h03 << {req_address_i[2:1], 1'b0};
            3'b010:  w_bytemask = 8'h0F << {req_address_i[2], 2'b00};
            3'b011:  w_bytemask = 8'hFF;
            default: w_bytemask = 8'h00;
        endcase
        w_bitmask = '0;
        for (int b = 0; b < 8; b++) begin
            w_bitmask[8*b +: 8] = {8{w_bytemask[b]}};
        end
    end

    always_comb begin
        w_supported = 1'b1;
        w_rtype     = RT_ERR;
        w_atomic    = 1'b0;
        w_d0        = '0;
        w_d1        = '0;
        w_d2        = '0;
        w_d3        = '0;
        w_wr_en     = 1'b0;
        w_wr_data   = w_old;
        case (req_rqtype_i)
            RQ_LOAD: begin
                w_rtype = RT_LOAD;
                if (req_size_i == 3'b111) begin
                    w_d0 = r_mem[w_idx_l2];
                    w_d1 = r_mem[w_idx_l2 | AW'(1)];
                end else begin
                    w_d0 = w_old;
                end
            end
            RQ_IMISS: begin
                w_rtype = RT_IFILL;
                w_d0    = r_mem[w_idx_l4];
                w_d1    = r_mem[w_idx_l4 | AW'(1)];
                w_d2    = r_mem[w_idx_l4 | AW'(2)];
                w_d3    = r_mem[w_idx_l4 | AW'(3)];
            end
            RQ_STORE: begin
                w_rtype   = RT_STACK;
                w_wr_en   = 1'b1;
                w_wr_data = (w_old & ~w_bitmask) | (req_data_i & w_bitmask);
            end
            RQ_ATOMIC: begin
                w_rtype  = RT_AMO;
                w_atomic = 1'b1;
                w_d0     = w_old;
                w_wr_en  = 1'b1;
                case (req_amo_op_i)
                    4'b0001: w_wr_data = req_data_i;
                    4'b0010: w_wr_data = w_old + req_data_i;
                    default: w_wr_data = w_old;
                endcase
            end
            default: begin
`ifdef L15_RESP_STUB_ERR_RET_EN
                w_supported = 1'b1;
`else
                w_supported = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acks are combinational so a held request is taken in its first IDLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_val_i && !rst_i) begin
                    w_accept = 1'b1;
                    if (w_supported) begin
                        w_state_nxt = (RespLatency == 1) ? S_RESP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (req_ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CW'(RespLatency - 1);
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // The whole memory operation happens at accept, so later requests see its effect.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_wr_en) begin
            r_mem[w_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rtype  <= '0;
            r_tid    <= '0;
            r_nc     <= 1'b0;
            r_atomic <= 1'b0;
            r_d0     <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_d3     <= '0;
        end else if (w_accept) begin
            r_rtype  <= w_rtype;
            r_tid    <= req_threadid_i;
            r_nc     <= req_nc_i;
            r_atomic <= w_atomic;
            r_d0     <= w_d0;
            r_d1     <= w_d1;
            r_d2     <= w_d2;
            r_d3     <= w_d3;
        end
    end

    assign w_resp              = (r_state == S_RESP);
    assign rtrn_ack_o          = w_accept;
    assign rtrn_header_ack_o   = w_accept;
    assign rtrn_val_o          = w_resp;
    assign rtrn_returntype_o   = w_resp ? r_rtype : '0;
    assign rtrn_threadid_o     = w_resp ? r_tid : '0;
    assign rtrn_noncacheable_o = w_resp & r_nc;
    assign rtrn_atomic_o       = w_resp & r_atomic;
    assign rtrn_data_0_o       = w_resp ? r_d0 : '0;
    assign rtrn_data_1_o       = w_resp ? r_d1 : '0;
    assign rtrn_data_2_o       = w_resp ? r_d2 : '0;
    assign rtrn_data_3_o       = w_resp ? r_d3 : '0;

endmodule

// File: tb/tb_l15_resp_stub.sv
// Directed bench for l15_resp_stub: stores, loads, fills, atomics, back-pressure, reset, unsupported types.
module tb_l15_resp_stub;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_val;
    logic [4:0]    req_rqtype;
    logic          req_nc;
    logic [2:0]    req_size;
    logic [TW-1:0] req_tid;
    logic [39:0]   req_addr;
    logic [63:0]   req_data;
    logic [3:0]    req_amo;
    logic          req_ack;
    logic          rtrn_ack_o, rtrn_header_ack_o, rtrn_val_o, rtrn_noncacheable_o, rtrn_atomic_o;
    logic [3:0]    rtrn_returntype_o;
    logic [TW-1:0] rtrn_threadid_o;
    logic [63:0]   rtrn_data_0_o, rtrn_data_1_o, rtrn_data_2_o, rtrn_data_3_o;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [63:0]   res_d0, res_d1, res_d2, res_d3;
    logic [3:0]    res_type;
    logic          res_atom;
    int            bad;
    logic [264:0]  snap;

    l15_resp_stub #(.TidWidth(TW), .MemWords(256), .RespLatency(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_val_i(req_val), .req_rqtype_i(req_rqtype),
        .req_nc_i(req_nc), .req_size_i(req_size), .req_threadid_i(req_tid),
        .req_address_i(req_addr), .req_data_i(req_data), .req_amo_op_i(req_amo),
        .req_ack_i(req_ack), .rtrn_ack_o(rtrn_ack_o), .rtrn_header_ack_o(rtrn_header_ack_o),
        .rtrn_val_o(rtrn_val_o), .rtrn_returntype_o(rtrn_returntype_o),
        .rtrn_threadid_o(rtrn_threadid_o), .rtrn_noncacheable_o(rtrn_noncacheable_o),
        .rtrn_atomic_o(rtrn_atomic_o), .rtrn_data_0_o(rtrn_data_0_o),
        .rtrn_data_1_o(rtrn_data_1_o), .rtrn_data_2_o(rtrn_data_2_o), .rtrn_data_3_o(rtrn_data_3_o)
    );

    always #5 clk = ~clk;

    function automatic logic [264:0] outs();
        return {rtrn_val_o, rtrn_returntype_o, rtrn_threadid_o, rtrn_noncacheable_o, rtrn_atomic_o,
                rtrn_data_0_o, rtrn_data_1_o, rtrn_data_2_o, rtrn_data_3_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge; returns at a falling edge with the return acknowledged.
    task automatic txn(input string tag, input logic [4:0] rq, input logic [2:0] sz,
                       input logic [39:0] addr, input logic [63:0] data, input logic [3:0] amo,
                       input logic [TW-1:0] tid, input logic nc);
        int guard;
        int lat;
        req_val = 1'b1; req_rqtype = rq; req_size = sz; req_addr = addr;
        req_data = data; req_amo = amo; req_tid = tid; req_nc = nc;
        #1;
        guard = 0;
        while (!rtrn_ack_o && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        chk({tag, "_ack"}, 64'(rtrn_ack_o & rtrn_header_ack_o), 64'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chk({tag, "_ackpulse"}, 64'(rtrn_ack_o | rtrn_header_ack_o), 64'd0);
        lat = 1;
        while (!rtrn_val_o && lat < 20) begin
            @(negedge clk); lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        res_d0 = rtrn_data_0_o; res_d1 = rtrn_data_1_o; res_d2 = rtrn_data_2_o; res_d3 = rtrn_data_3_o;
        res_type = rtrn_returntype_o; res_atom = rtrn_atomic_o;
        chk({tag, "_tid"}, 64'(rtrn_threadid_o), 64'(tid));
        chk({tag, "_nc"}, 64'(rtrn_noncacheable_o), 64'(nc));
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, 64'(rtrn_val_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_val = 1'b1; req_rqtype = 5'b00000; req_nc = 1'b0; req_size = 3'b011;
        req_tid = '0; req_addr = '0; req_data = '0; req_amo = '0; req_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(rtrn_ack_o | rtrn_header_ack_o), 64'd0);
        chk("rst_outs", 64'(|outs()), 64'd0);
        req_val = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        txn("st40", 5'b00001, 3'b011, 40'h40, 64'h1122334455667788, 4'h0, 2'd1, 1'b0);
        chk("st40_type", 64'(res_type), 64'h4);
        chk("st40_data", res_d0 | res_d1 | res_d2 | res_d3, 64'd0);
        txn("ld40", 5'b00000, 3'b011, 40'h40, 64'd0, 4'h0, 2'd2, 1'b1);
        chk("ld40_type", 64'(res_type), 64'h0);
        chk("ld40_d0", res_d0, 64'h1122334455667788);
        chk("ld40_d1", res_d1, 64'd0);

        txn("clr40", 5'b00001, 3'b011, 40'h40, 64'd0, 4'h0, 2'd0, 1'b0);
        txn("stb43", 5'b00001, 3'b000, 40'h43, 64'h00000000AB000000, 4'h0, 2'd3, 1'b0);
        txn("ldb43", 5'b00000, 3'b011, 40'h40, 64'd0, 4'h0, 2'd3, 1'b0);
        chk("ldb43_d0", res_d0, 64'h00000000AB000000);
        txn("sth46", 5'b00001, 3'b001, 40'h46, 64'hBEEF000000000000, 4'h0, 2'd1, 1'b1);
        txn("ldh46", 5'b00000, 3'b011, 40'h40, 64'd0, 4'h0, 2'd1, 1'b0);
        chk("ldh46_d0", res_d0, 64'hBEEF0000AB000000);

        for (int i = 0; i < 4; i++) begin
            txn("stline", 5'b00001, 3'b011, 40'h80 + 40'(8 * i), 64'(i + 1), 4'h0, 2'd0, 1'b0);
        end
        txn("imiss", 5'b10000, 3'b000, 40'h90, 64'd0, 4'h0, 2'd2, 1'b0);
        chk("imiss_type", 64'(res_type), 64'h1);
        chk("imiss_d0", res_d0, 64'd1);
        chk("imiss_d1", res_d1, 64'd2);
        chk("imiss_d2", res_d2, 64'd3);
        chk("imiss_d3", res_d3, 64'd4);
        txn("ld16", 5'b00000, 3'b111, 40'h98, 64'd0, 4'h0, 2'd1, 1'b0);
        chk("ld16_d0", res_d0, 64'd3);
        chk("ld16_d1", res_d1, 64'd4);
        chk("ld16_d23", res_d2 | res_d3, 64'd0);
        txn("alias", 5'b00000, 3'b011, 40'h880, 64'd0, 4'h0, 2'd0, 1'b0);
        chk("alias_d0", res_d0, 64'd1);

        txn("st8", 5'b00001, 3'b011, 40'h8, 64'd5, 4'h0, 2'd0, 1'b0);
        txn("add", 5'b00110, 3'b011, 40'h8, 64'd3, 4'h2, 2'd3, 1'b1);
        chk("add_type", 64'(res_type), 64'hE);
        chk("add_old", res_d0, 64'd5);
        chk("add_atom", 64'(res_atom), 64'd1);
        txn("ldadd", 5'b00000, 3'b011, 40'h8, 64'd0, 4'h0, 2'd0, 1'b0);
        chk("ldadd_d0", res_d0, 64'd8);
        chk("ldadd_atom", 64'(res_atom), 64'd0);
        txn("swap", 5'b00110, 3'b011, 40'h8, 64'h77, 4'h1, 2'd1, 1'b0);
        chk("swap_old", res_d0, 64'd8);
        txn("amonop", 5'b00110, 3'b011, 40'h8, 64'h99, 4'h5, 2'd1, 1'b0);
        chk("amonop_old", res_d0, 64'h77);
        txn("ldswap", 5'b00000, 3'b011, 40'h8, 64'd0, 4'h0, 2'd0, 1'b0);
        chk("ldswap_d0", res_d0, 64'h77);

        // Back-pressure with a second request already waiting.
        req_val = 1'b1; req_rqtype = 5'b00000; req_size = 3'b011; req_addr = 40'h80;
        req_tid = 2'd1; req_nc = 1'b0;
        #1;
        chk("stall_ack1", 64'(rtrn_ack_o), 64'd1);
        @(posedge clk); #1;
        req_addr = 40'h88; req_tid = 2'd2;
        bad = 0;
        @(negedge clk); if (rtrn_ack_o) bad++;
        @(negedge clk); if (rtrn_ack_o) bad++;
        chk("stall_val", 64'(rtrn_val_o), 64'd1);
        chk("stall_d0", rtrn_data_0_o, 64'd1);
        snap = outs();
        repeat (10) begin
            @(negedge clk);
            if (outs() !== snap || rtrn_ack_o || rtrn_header_ack_o) bad++;
        end
        chk("stall_stable", 64'(bad), 64'd0);
        req_ack = 1'b1;
        #1;
        chk("stall_noack", 64'(rtrn_ack_o), 64'd0);
        @(posedge clk); #1;
        req_ack = 1'b0;
        chk("stall_ack2", 64'(rtrn_ack_o), 64'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("stall2_val", 64'(rtrn_val_o), 64'd1);
        chk("stall2_d0", rtrn_data_0_o, 64'd2);
        chk("stall2_tid", 64'(rtrn_threadid_o), 64'd2);
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        @(negedge clk);

        // Reset while waiting, with the request still presented.
        req_val = 1'b1; req_addr = 40'h80; req_tid = 2'd3; req_nc = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw_ack", 64'(rtrn_ack_o | rtrn_header_ack_o), 64'd0);
        chk("rstw_outs", 64'(|outs()), 64'd0);
        @(negedge clk); @(negedge clk);
        req_val = 1'b0;
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rtrn_val_o) bad++;
        end
        chk("rstw_noret", 64'(bad), 64'd0);

        // Reset while a return is being presented.
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rstr_val_pre", 64'(rtrn_val_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstr_outs", 64'(|outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef L15_RESP_STUB_ERR_RET_EN
        txn("err", 5'b01010, 3'b011, 40'h80, 64'd0, 4'h0, 2'd2, 1'b0);
        chk("err_type", 64'(res_type), 64'hC);
        chk("err_data", res_d0 | res_d1 | res_d2 | res_d3, 64'd0);
`else
        req_val = 1'b1; req_rqtype = 5'b01010; req_tid = 2'd2;
        #1;
        chk("unsup_ack", 64'(rtrn_ack_o), 64'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rtrn_val_o) bad++;
        end
        chk("unsup_noval", 64'(bad), 64'd0);
`endif
        txn("post", 5'b00000, 3'b011, 40'h98, 64'd0, 4'h0, 2'd1, 1'b0);
        chk("post_d0", res_d0, 64'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
